// File: rtl/cim_tile.sv
// One CIM crossbar tile: 1-bit weight array, bit-parallel row-serial MVM,
// ADC quantisation into a registered read-port output buffer.
module cim_tile #(
    parameter int xbar_size     = 256,
    parameter int datatype_size = 2,
    parameter int out_width     = 2,
    parameter int adc_shift     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_wgt_we,
    input  logic [$clog2(xbar_size)-1:0] i_wgt_row,
    input  logic [xbar_size-1:0]         i_wgt_data,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [out_width-1:0]         o_rd_data
);

    localparam int AW    = $clog2(xbar_size);
    localparam int ACC_W = AW + datatype_size;
    localparam logic [out_width-1:0] OUT_MAX   = '1;
    localparam logic [ACC_W-1:0]     OUT_MAX_W = ACC_W'(OUT_MAX);

    typedef enum logic [1:0] {IDLE, COMPUTE, CONVERT, DONE} state_t;

    state_t state, next_state;

    logic [datatype_size-1:0] in_buf  [xbar_size];
    logic [xbar_size-1:0]     wgt     [xbar_size];
    logic [ACC_W-1:0]         acc     [xbar_size];
    logic [out_width-1:0]     out_buf [xbar_size];
    logic [out_width-1:0]     sat     [xbar_size];
    logic [AW-1:0]            row;
    logic                     last_row;
    logic                     accept_start;

    assign last_row = (row == AW'(xbar_size - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept_start = 1'b1;
                    next_state   = COMPUTE;
                end
            end
            COMPUTE: begin
                o_busy = 1'b1;
                if (last_row) next_state = CONVERT;
            end
            CONVERT: begin
                o_busy     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    accept_start = 1'b1;
                    next_state   = COMPUTE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ADC model: shift then clamp to the output code range.
    always_comb begin
        logic [ACC_W-1:0] shifted;
        shifted = '0;
        for (int c = 0; c < xbar_size; c++) begin
            shifted = acc[c] >> adc_shift;
            sat[c]  = (shifted > OUT_MAX_W) ? OUT_MAX : shifted[out_width-1:0];
        end
    end

    // NOTE: the weight array carries no reset; it is always written before
    // use and clearing it would only add a reset fan-out to every bit cell.
    always_ff @(posedge clk) begin
        if (i_wgt_we && !o_busy) wgt[i_wgt_row] <= i_wgt_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            o_rd_data <= '0;
            for (int c = 0; c < xbar_size; c++) begin
                acc[c]     <= '0;
                in_buf[c]  <= '0;
                out_buf[c] <= '0;
            end
        end else begin
            o_rd_data <= out_buf[i_rd_addr];
            // Writes during a run are dropped so operands stay stable.
            if (i_we && !o_busy) in_buf[i_wr_addr] <= i_wr_data;
            if (accept_start) begin
                row <= '0;
                for (int c = 0; c < xbar_size; c++) acc[c] <= '0;
            end else if (state == COMPUTE) begin
                row <= row + AW'(1);
                for (int c = 0; c < xbar_size; c++)
                    acc[c] <= acc[c] + (wgt[row][c] ? ACC_W'(in_buf[row]) : '0);
            end
            if (state == CONVERT) begin
                for (int c = 0; c < xbar_size; c++) out_buf[c] <= sat[c];
            end
        end
    end

endmodule

// File: tb/tb_cim_tile.sv
// Directed self-checking bench for cim_tile (4x4 tile); a second instance
// with adc_shift=2 shares the stimulus to cover the shifted ADC path.
module tb_cim_tile;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_we = 1'b0;
    logic [1:0] i_wr_addr = '0;
    logic [1:0] i_wr_data = '0;
    logic       i_wgt_we = 1'b0;
    logic [1:0] i_wgt_row = '0;
    logic [3:0] i_wgt_data = '0;
    logic       i_start = 1'b0;
    logic [1:0] i_rd_addr = '0;
    logic       busy0, done0, busy2, done2;
    logic [1:0] rd0, rd2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cim_tile #(.xbar_size(N), .datatype_size(2), .out_width(2), .adc_shift(0)) dut0 (
        .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_data(i_wgt_data),
        .i_start(i_start), .o_busy(busy0), .o_done(done0),
        .i_rd_addr(i_rd_addr), .o_rd_data(rd0)
    );

    cim_tile #(.xbar_size(N), .datatype_size(2), .out_width(2), .adc_shift(2)) dut2 (
        .clk(clk), .rst(rst), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_wgt_we(i_wgt_we), .i_wgt_row(i_wgt_row), .i_wgt_data(i_wgt_data),
        .i_start(i_start), .o_busy(busy2), .o_done(done2),
        .i_rd_addr(i_rd_addr), .o_rd_data(rd2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_in(input int addr, input int data);
        i_we = 1'b1; i_wr_addr = 2'(addr); i_wr_data = 2'(data);
        tick();
        i_we = 1'b0;
    endtask

    task automatic write_wgt(input int r, input logic [3:0] bits);
        i_wgt_we = 1'b1; i_wgt_row = 2'(r); i_wgt_data = bits;
        tick();
        i_wgt_we = 1'b0;
    endtask

    task automatic load_vec(input int a, input int b, input int c, input int d);
        write_in(0, a); write_in(1, b); write_in(2, c); write_in(3, d);
    endtask

    // Start a run and wait (bounded) for o_done; latency must be N+2.
    task automatic run_and_wait(input string tag);
        int cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cnt = 1;
        while (!done0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), N + 2);
    endtask

    task automatic read_col(input string tag, input int col, input int exp0, input int exp2);
        i_rd_addr = 2'(col);
        tick();
        check($sformatf("%s_col%0d_s0", tag, col), 32'(rd0), exp0);
        check($sformatf("%s_col%0d_s2", tag, col), 32'(rd2), exp2);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done0) n++;
            tick();
        end
    endtask

    initial begin
        int n_done;
        int cnt;

        // Reset held for two cycles.
        tick(); tick();
        check("rst_busy0", 32'(busy0), 0);
        check("rst_done0", 32'(done0), 0);
        check("rst_busy2", 32'(busy2), 0);
        check("rst_done2", 32'(done2), 0);
        rst = 1'b0;
        for (int c = 0; c < N; c++) read_col("rst", c, 0, 0);

        // Identity weights, inputs [1,2,3,0], explicit cycle timing.
        for (int r = 0; r < N; r++) write_wgt(r, 4'b0001 << r);
        load_vec(1, 2, 3, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            check($sformatf("id_busy_t%0d", k), 32'(busy0), 1);
            check($sformatf("id_nodone_t%0d", k), 32'(done0), 0);
            tick();
        end
        check("id_done", 32'(done0), 1);
        check("id_done_busy", 32'(busy0), 0);
        tick();
        check("id_done_pulse", 32'(done0), 0);
        read_col("id", 0, 1, 0);
        i_rd_addr = 2'd1;
        #1;
        check("id_rd_registered", 32'(rd0), 1);
        read_col("id", 1, 2, 0);
        read_col("id", 2, 3, 0);
        read_col("id", 3, 0, 0);

        // All weights 1: saturation and shifted ADC.
        for (int r = 0; r < N; r++) write_wgt(r, 4'b1111);
        load_vec(3, 3, 3, 3);
        run_and_wait("ones3");
        for (int c = 0; c < N; c++) read_col("ones3", c, 3, 3);
        load_vec(1, 1, 1, 0);
        run_and_wait("ones1");
        for (int c = 0; c < N; c++) read_col("ones1", c, 3, 0);

        // Busy protection: writes and start during a run are dropped.
        load_vec(1, 0, 0, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        write_in(0, 3);
        write_wgt(0, 4'b0000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        count_dones(12, n_done);
        check("busy_single_done", 32'(n_done), 1);
        for (int c = 0; c < N; c++) read_col("busy", c, 1, 0);
        run_and_wait("rerun");
        for (int c = 0; c < N; c++) read_col("rerun", c, 1, 0);

        // Reset in the middle of a run.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy0), 0);
        count_dones(10, n_done);
        check("abort_no_done", 32'(n_done), 0);
        for (int c = 0; c < N; c++) read_col("abort", c, 0, 0);

        // Back-to-back: start accepted in the DONE cycle.
        for (int r = 0; r < N; r++) write_wgt(r, 4'b1111);
        load_vec(1, 2, 3, 0);
        run_and_wait("b2b_first");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("b2b_busy", 32'(busy0), 1);
        cnt = 1;
        while (!done0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("b2b_second_done", 32'(cnt), N + 2);
        read_col("b2b", 0, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
